// File: rtl/ifu_fetch.sv
// Instruction fetch unit: owns the PC, issues one imem read at a time and buffers the
// returned word for decode. Redirects flush any fetch in flight via the drop flag.
module ifu_fetch #(
   parameter logic [63:0] RESET_PC = 64'h0000_0000_8000_0000,
   parameter logic [31:0] NOP_INST = 32'h0000_0013
) (
   input  logic        clk,
   input  logic        rst,
   output logic        imem_req_valid,
   input  logic        imem_req_ready,
   output logic [63:0] imem_req_addr,
   input  logic        imem_rsp_valid,
   output logic        imem_rsp_ready,
   input  logic [31:0] imem_rsp_data,
   input  logic        imem_rsp_err,
   input  logic        redirect_valid,
   input  logic [63:0] redirect_pc,
   output logic        out_valid,
   input  logic        out_ready,
   output logic [31:0] out_inst,
   output logic [63:0] out_pc,
   output logic        out_fault
);

   typedef enum logic [1:0] {S_REQ, S_WAIT, S_HOLD} state_t;

   typedef struct packed {
      logic [31:0] inst;
      logic [63:0] pc;
      logic        fault;
   } fetch_out_t;

   state_t      state, state_nxt;
   logic [63:0] pc, pc_nxt;
   logic        drop, drop_nxt;
   logic        ld_buf;
   fetch_out_t  buf_nxt;
   logic        req_hs;

   assign imem_req_addr  = pc;
   assign imem_req_valid = !rst && (state == S_REQ) && (pc[1:0] == 2'b00);
   assign imem_rsp_ready = !rst && (state == S_WAIT);
   assign req_hs         = imem_req_valid && imem_req_ready;

   always_comb begin
      state_nxt = state;
      pc_nxt    = pc;
      drop_nxt  = drop;
      ld_buf    = 1'b0;
      buf_nxt   = '{inst: NOP_INST, pc: pc, fault: 1'b1};

      case (state)
         S_REQ: begin
            if (pc[1:0] != 2'b00) begin
               ld_buf    = 1'b1;
               state_nxt = S_HOLD;
            end else if (req_hs) begin
               state_nxt = S_WAIT;
            end
         end
         S_WAIT: begin
            if (imem_rsp_valid) begin
               if (drop) begin
                  drop_nxt  = 1'b0;
                  state_nxt = S_REQ;
               end else begin
                  ld_buf        = 1'b1;
                  buf_nxt.inst  = imem_rsp_data;
                  buf_nxt.fault = imem_rsp_err;
                  // a faulted fetch keeps pc so the trap reports the offending address
                  pc_nxt        = imem_rsp_err ? pc : pc + 64'd4;
                  state_nxt     = S_HOLD;
               end
            end
         end
         S_HOLD: begin
            if (out_ready) state_nxt = S_REQ;
         end
         default: state_nxt = S_REQ;
      endcase

      // redirect overrides everything; an accepted request still owes us one response
      if (redirect_valid) begin
         pc_nxt = redirect_pc;
         ld_buf = 1'b0;
         case (state)
            S_REQ: begin
               state_nxt = req_hs ? S_WAIT : S_REQ;
               drop_nxt  = req_hs ? 1'b1 : drop;
            end
            S_WAIT: begin
               state_nxt = imem_rsp_valid ? S_REQ : S_WAIT;
               drop_nxt  = !imem_rsp_valid;
            end
            default: state_nxt = S_REQ;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state     <= S_REQ;
         pc        <= RESET_PC;
         drop      <= 1'b0;
         out_valid <= 1'b0;
         out_inst  <= NOP_INST;
         out_pc    <= '0;
         out_fault <= 1'b0;
      end else begin
         state     <= state_nxt;
         pc        <= pc_nxt;
         drop      <= drop_nxt;
         out_valid <= (state_nxt == S_HOLD);
         if (ld_buf) begin
            out_inst  <= buf_nxt.inst;
            out_pc    <= buf_nxt.pc;
            out_fault <= buf_nxt.fault;
         end
      end
   end

endmodule
